// File: rtl/friscv_rv32i_fetch.sv
// Instruction prefetch stage: sequential word reads are issued ahead of demand and buffered in order.
// Optional same-cycle forwarding of a response on an empty FIFO: define FRISCV_FETCH_BYPASS_EN.
module friscv_rv32i_fetch #(
  parameter int               ADDRW     = 16,
  parameter logic [ADDRW-1:0] BOOT_ADDR = {ADDRW{1'b0}},
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 4
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             inst_en,
  input  logic [ADDRW-1:0] inst_addr,
  output logic [XLEN-1:0]  inst_rdata,
  output logic             inst_ready,
  output logic             mem_en,
  output logic [ADDRW-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRW-1:0] r_head_addr;
  logic [ADDRW-1:0] r_fetch_addr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_discard_cnt;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [XLEN-1:0]  r_fifo [DEPTH];
  logic             r_rst_q;

  logic w_hit;
  logic w_redirect;
  logic w_credit_ok;
  logic w_issue;
  logic w_bypass;
  logic w_pop;
  logic w_push;

  // Handshakes: a memory request transfers when mem_en && mem_ready; an instruction
  // transfers when inst_ready (inst_en held until then); mem_rvalid has no backpressure.
  always_comb begin
    w_hit       = inst_en && (inst_addr == r_head_addr);
    w_redirect  = inst_en && !w_hit;
    w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
    // Held low for the reset cycle and the one after it.
    mem_en      = !srst && !r_rst_q && !w_redirect && w_credit_ok;
    mem_addr    = r_fetch_addr;
    w_issue     = mem_en && mem_ready;
`ifdef FRISCV_FETCH_BYPASS_EN
    w_bypass    = w_hit && mem_rvalid && (r_count == '0) && (r_discard_cnt == '0);
`else
    w_bypass    = 1'b0;
`endif
    w_pop       = w_hit && (r_count != '0);
    w_push      = mem_rvalid && !w_redirect && (r_discard_cnt == '0) && !w_bypass;
    inst_ready  = w_pop || w_bypass;
    inst_rdata  = '0;
    if (w_pop) begin
      inst_rdata = r_fifo[r_rptr];
    end else if (w_bypass) begin
      inst_rdata = mem_rdata;
    end
  end

  always_ff @(posedge aclk) begin
    r_rst_q <= srst;
    if (srst) begin
      r_head_addr   <= BOOT_ADDR;
      r_fetch_addr  <= BOOT_ADDR;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(mem_rvalid);
      if (w_redirect) begin
        // Everything still in flight belongs to the old stream, minus the one dropped now.
        r_head_addr   <= inst_addr;
        r_fetch_addr  <= inst_addr;
        r_count       <= '0;
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_discard_cnt <= r_outstanding - CW'(mem_rvalid);
      end else begin
        if (w_issue) begin
          r_fetch_addr <= r_fetch_addr + ADDRW'(4);
        end
        if (inst_ready) begin
          r_head_addr <= r_head_addr + ADDRW'(4);
        end
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (mem_rvalid && (r_discard_cnt != '0)) begin
          r_discard_cnt <= r_discard_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!srst && w_push) begin
      r_fifo[r_wptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_friscv_rv32i_fetch.sv
// Directed bench for friscv_rv32i_fetch: fixed-latency memory responder plus an
// in-order scoreboard of expected instructions.
module tb_friscv_rv32i_fetch;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic             aclk = 1'b0;
  logic             srst;
  logic             inst_en;
  logic [ADDRW-1:0] inst_addr;
  logic [XLEN-1:0]  inst_rdata;
  logic             inst_ready;
  logic             mem_en;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic [XLEN-1:0]  sb_e;
  logic [ADDRW-1:0] pend_a[$];
  int               pend_t[$];
  int               cyc = 0;

  friscv_rv32i_fetch #(
    .ADDRW(ADDRW), .BOOT_ADDR('0), .XLEN(XLEN), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .srst(srst),
    .inst_en(inst_en), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 aclk = ~aclk;

  function automatic logic [XLEN-1:0] mem_word(input logic [ADDRW-1:0] a);
    return 32'h0000_0013 + {18'd0, a[15:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Called just after an active edge; returns at the falling edge where inst_ready was seen.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge aclk);
    while (!inst_ready && n < 30) begin
      step();
      @(negedge aclk);
      n++;
    end
    check(tag, {31'd0, inst_ready}, 32'd1);
  endtask

  task automatic deliver(input logic [ADDRW-1:0] a, input string tag);
    inst_en   = 1'b1;
    inst_addr = a;
    exp_q.push_back(mem_word(a));
    wait_ready(tag);
    step();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step();
    step();
    @(negedge aclk);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    step();
    srst = 1'b0;
    @(negedge aclk);
    check("rst_release_mem_en", {31'd0, mem_en}, 32'd0);
    step();
  endtask

  // Memory model: accepts on the falling-edge view of mem_en && mem_ready, answers LAT cycles later.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge aclk);
      if (srst) begin
        pend_a.delete();
        pend_t.delete();
      end else if (mem_en && mem_ready) begin
        pend_a.push_back(mem_addr);
        pend_t.push_back(cyc + LAT);
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // Scoreboard: every delivered instruction must be the oldest expected one.
  initial begin
    forever begin
      @(negedge aclk);
      if (inst_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_stale", {31'd0, inst_ready}, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_rdata", inst_rdata, sb_e);
        end
      end else begin
        check("idle_rdata", inst_rdata, 32'd0);
      end
    end
  end

  initial begin
    srst      = 1'b1;
    inst_en   = 1'b0;
    inst_addr = '0;
    mem_ready = 1'b1;
    do_reset();

    // Fill: four back-to-back requests, then the credit limit holds mem_en low.
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("fill_mem_en", {31'd0, mem_en}, 32'd1);
      check("fill_mem_addr", {16'd0, mem_addr}, 32'(4 * i));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check("fill_cap", {31'd0, mem_en}, 32'd0);
      step();
    end

    // Streaming: one instruction per cycle in address order.
    for (int i = 0; i < 8; i++) begin
      inst_en   = 1'b1;
      inst_addr = 16'(4 * i);
      exp_q.push_back(mem_word(16'(4 * i)));
      @(negedge aclk);
      check("stream_ready", {31'd0, inst_ready}, 32'd1);
      if (i == 0) check("stream_full_no_issue", {31'd0, mem_en}, 32'd0);
      if (i == 1) begin
        check("stream_reissue", {31'd0, mem_en}, 32'd1);
        check("stream_reissue_addr", {16'd0, mem_addr}, 32'h10);
      end
      step();
    end
    inst_en = 1'b0;
    repeat (10) step();
    @(negedge aclk);
    check("idle_cap", {31'd0, mem_en}, 32'd0);
    step();

    // Redirect with 0x24..0x2C buffered and 0x30 in flight.
    deliver(16'h20, "redir_pre_pop");
    inst_en = 1'b0;
    @(negedge aclk);
    check("redir_pre_issue", {31'd0, mem_en}, 32'd1);
    check("redir_pre_addr", {16'd0, mem_addr}, 32'h30);
    step();
    inst_en   = 1'b1;
    inst_addr = 16'h100;
    exp_q.push_back(mem_word(16'h100));
    @(negedge aclk);
    check("redir_mem_en", {31'd0, mem_en}, 32'd0);
    check("redir_no_ready", {31'd0, inst_ready}, 32'd0);
    step();
    @(negedge aclk);
    check("redir_new_en", {31'd0, mem_en}, 32'd1);
    check("redir_new_addr", {16'd0, mem_addr}, 32'h100);
    step();
    wait_ready("redir_first");
    step();
    deliver(16'h104, "redir_seq1");
    deliver(16'h108, "redir_seq2");
    inst_en = 1'b0;
    repeat (10) step();

    // Redirect in the same cycle as a response, with a second one still in flight.
    deliver(16'h10C, "coll_pop0");
    deliver(16'h110, "coll_pop1");
    inst_en = 1'b0;
    @(negedge aclk);
    check("coll_issue", {31'd0, mem_en}, 32'd1);
    step();
    inst_en   = 1'b1;
    inst_addr = 16'h200;
    exp_q.push_back(mem_word(16'h200));
    @(negedge aclk);
    check("coll_rvalid", {31'd0, mem_rvalid}, 32'd1);
    check("coll_mem_en", {31'd0, mem_en}, 32'd0);
    check("coll_no_ready", {31'd0, inst_ready}, 32'd0);
    step();
    @(negedge aclk);
    check("coll_new_addr", {16'd0, mem_addr}, 32'h200);
    step();
    wait_ready("coll_first");
    step();
    inst_en = 1'b0;

    // Memory stall on the third request.
    do_reset();
    step();
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_mem_en", {31'd0, mem_en}, 32'd1);
      check("stall_mem_addr", {16'd0, mem_addr}, 32'h8);
      step();
    end
    mem_ready = 1'b1;
    @(negedge aclk);
    check("stall_accept_addr", {16'd0, mem_addr}, 32'h8);
    step();
    @(negedge aclk);
    check("stall_after_addr", {16'd0, mem_addr}, 32'hC);
    step();

    // Reset pulse with three buffered entries and one request in flight.
    repeat (10) step();
    deliver(16'h0, "srst_pre_pop");
    inst_en = 1'b0;
    @(negedge aclk);
    check("srst_pre_issue", {16'd0, mem_addr}, 32'h10);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    @(negedge aclk);
    check("srst_mem_en", {31'd0, mem_en}, 32'd0);
    check("srst_inst_ready", {31'd0, inst_ready}, 32'd0);
    check("srst_mem_addr", {16'd0, mem_addr}, 32'd0);
    step();
    @(negedge aclk);
    check("srst_restart_en", {31'd0, mem_en}, 32'd1);
    check("srst_restart_addr", {16'd0, mem_addr}, 32'd0);
    step();
    @(negedge aclk);
    check("srst_second_addr", {16'd0, mem_addr}, 32'h4);
    step();
    deliver(16'h0, "srst_deliver0");
    deliver(16'h4, "srst_deliver1");
    inst_en = 1'b0;

    repeat (5) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
